alu_flag_stage: RTL and testbench

// - Downstream stage of the 8-bit combinational ALU: captures {op, op_a, op_b, result} under valid/ready.
// - Computes status flags Z/N/C/V/ILL and buffers result+flags in a DEPTH-entry FIFO toward writeback.
// - Decouples the combinational ALU from consumer back-pressure; one-cycle minimum latency.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_flag_calc.sv | 45 ++++
 rtl/alu_flag_stage.sv | 85 ++++++++
 tb/tb_alu_flag_stage.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and status-flag bit positions.
// The combinational ALU and the flag stage both import these.
package alu_pkg;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] NOT = 3'b101;

  localparam int FLG_Z   = 0;
  localparam int FLG_N   = 1;
  localparam int FLG_C   = 2;
  localparam int FLG_V   = 3;
  localparam int FLG_ILL = 4;
  localparam int FLAG_W  = 5;

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational status-flag derivation from an ALU operation and its result.
// in_result is trusted; flags describe it, they do not validate it.
module alu_flag_calc
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic [OP_W-1:0]   op,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic [WIDTH-1:0]  result,
  output logic [FLAG_W-1:0] flags
);

  logic [WIDTH:0] sum;
  logic           a_msb;
  logic           b_msb;
  logic           r_msb;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign a_msb = a[WIDTH-1];
  assign b_msb = b[WIDTH-1];
  assign r_msb = result[WIDTH-1];

  always_comb begin
    flags        = '0;
    flags[FLG_Z] = (result == '0);
    flags[FLG_N] = r_msb;
    case (op)
      ADD: begin
        flags[FLG_C] = sum[WIDTH];
        flags[FLG_V] = (a_msb == b_msb) && (r_msb != a_msb);
      end
      SUB: begin
        // C reports borrow, not the inverted carry of a two's-complement add.
        flags[FLG_C] = (a < b);
        flags[FLG_V] = (a_msb != b_msb) && (r_msb != a_msb);
      end
      AND, OR, XOR, NOT: ;
      default: flags[FLG_ILL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_flag_stage.sv
// ALU downstream stage: tags each accepted result with status flags and
// buffers {op, flags, result} in a small FIFO toward writeback.
module alu_flag_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [WIDTH-1:0]           in_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_result,
  output logic [FLAG_W-1:0]          out_flags,
  output logic [OP_W-1:0]            out_op,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0]  mem_result [DEPTH];
  logic [FLAG_W-1:0] mem_flags  [DEPTH];
  logic [OP_W-1:0]   mem_op     [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [FLAG_W-1:0] in_flags;
  logic              push;
  logic              pop;

  alu_flag_calc #(.WIDTH(WIDTH), .OP_W(OP_W)) u_flag_calc (
    .op     (in_op),
    .a      (in_a),
    .b      (in_b),
    .result (in_result),
    .flags  (in_flags)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready on
  // that side; valid never depends on ready, and in_ready depends only on level.
  assign in_ready  = (level != LVL_W'(DEPTH));
  assign out_valid = (level != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_result = mem_result[rd_ptr];
  assign out_flags  = mem_flags[rd_ptr];
  assign out_op     = mem_op[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_result[i] <= '0;
        mem_flags[i]  <= '0;
        mem_op[i]     <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem_result[wr_ptr] <= in_result;
        mem_flags[wr_ptr]  <= in_flags;
        mem_op[wr_ptr]     <= in_op;
        wr_ptr             <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_flag_stage.sv
// Bench for alu_flag_stage: directed flag table, back-pressure, streaming,
// mid-stream reset and randomized traffic against a queue-based model.
module tb_alu_flag_stage;

  localparam int WIDTH = 8;
  localparam int OP_W  = 3;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] in_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [4:0]       out_flags;
  logic [OP_W-1:0]  out_op;
  logic [1:0]       level;

  alu_flag_stage #(.WIDTH(WIDTH), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_op     (out_op),
    .level      (level)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pop_cnt = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic [4:0] flags; // {ILL,V,C,N,Z}
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model in plain integer arithmetic.
  function automatic int sval(input logic [7:0] x);
    return (x > 127) ? int'(x) - 256 : int'(x);
  endfunction

  function automatic logic [7:0] model_result(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: return 8'((int'(a) + int'(b)) % 256);
      3'd1: return 8'((int'(a) - int'(b) + 256) % 256);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [4:0] model_flags(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] r);
    logic z, n, c, v, ill;
    int s;
    z = (r == 0);
    n = (r >= 128);
    c = 1'b0; v = 1'b0; ill = 1'b0;
    if (op == 3'd0) begin
      c = (int'(a) + int'(b)) > 255;
      s = sval(a) + sval(b);
      v = (s > 127) || (s < -128);
    end else if (op == 3'd1) begin
      c = int'(a) < int'(b);
      s = sval(a) - sval(b);
      v = (s > 127) || (s < -128);
    end else if (op > 3'd5) begin
      ill = 1'b1;
    end
    return {ill, v, c, n, z};
  endfunction

  // One cycle of scoreboard bookkeeping; inputs are already driven at the negedge.
  task automatic tick();
    #1;
    chk("level", 32'(level), 32'(exp_q.size()));
    chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (out_valid && exp_q.size() != 0)
      chk("head", 32'({out_op, out_flags, out_result}), 32'(exp_q[0]));
    if (out_valid && out_ready && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      pop_cnt++;
    end
    if (in_valid && in_ready)
      exp_q.push_back({in_op, model_flags(in_op, in_a, in_b, in_result), in_result});
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] r);
    in_valid = v; in_op = op; in_a = a; in_b = b; in_result = r;
  endtask

  vec_t vecs[12];
  int   pc0;

  initial begin
    vecs[0]  = '{3'b000, 8'hFF, 8'h01, 8'h00, 5'b00101};
    vecs[1]  = '{3'b000, 8'h7F, 8'h01, 8'h80, 5'b01010};
    vecs[2]  = '{3'b001, 8'h00, 8'h01, 8'hFF, 5'b00110};
    vecs[3]  = '{3'b001, 8'h80, 8'h01, 8'h7F, 5'b01000};
    vecs[4]  = '{3'b110, 8'h12, 8'h34, 8'h00, 5'b10001};
    vecs[5]  = '{3'b100, 8'hAA, 8'h55, 8'hFF, 5'b00010};
    vecs[6]  = '{3'b010, 8'h0F, 8'hF0, 8'h00, 5'b00001};
    vecs[7]  = '{3'b000, 8'h80, 8'h80, 8'h00, 5'b01101};
    vecs[8]  = '{3'b111, 8'h00, 8'h00, 8'h80, 5'b10010};
    vecs[9]  = '{3'b101, 8'h00, 8'h77, 8'hFF, 5'b00010};
    vecs[10] = '{3'b011, 8'h00, 8'h00, 8'h00, 5'b00001};
    vecs[11] = '{3'b001, 8'h05, 8'h03, 8'h02, 5'b00000};

    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_level", 32'(level), 0);
    chk("rst_out_result", 32'(out_result), 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    chk("rst_out_op", 32'(out_op), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed flag table
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r);
      out_ready = 1'b0;
      tick();
      drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
      #1;
      chk($sformatf("vec%0d_result", i), 32'(out_result), 32'(vecs[i].r));
      chk($sformatf("vec%0d_flags", i), 32'(out_flags), 32'(vecs[i].flags));
      chk($sformatf("vec%0d_op", i), 32'(out_op), 32'(vecs[i].op));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end

    // back-pressure: three pushes against a stalled consumer
    pc0 = pop_cnt;
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 8'h01, 8'h02, 8'h03); tick();
    drive(1'b1, 3'd1, 8'h09, 8'h04, 8'h05); tick();
    drive(1'b1, 3'd3, 8'h30, 8'h0C, 8'h3C);
    repeat (3) tick();
    chk("bp_stall_level", 32'(level), 2);
    chk("bp_stall_ready", 32'(in_ready), 0);
    chk("bp_head_hold", 32'(out_result), 32'h03);
    out_ready = 1'b1;
    tick();
    drive(1'b1, 3'd3, 8'h30, 8'h0C, 8'h3C);
    tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    repeat (3) tick();
    chk("bp_pop_count", 32'(pop_cnt - pc0), 3);

    // streaming at level 1
    out_ready = 1'b0;
    drive(1'b1, 3'd2, 8'hF0, 8'h3C, 8'h30); tick();
    out_ready = 1'b1;
    pc0 = pop_cnt;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 3'd0, 8'(i), 8'(3 * i), model_result(3'd0, 8'(i), 8'(3 * i)));
      tick();
    end
    chk("stream_pops", 32'(pop_cnt - pc0), 16);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    repeat (2) tick();

    // reset mid-stream with level=2
    out_ready = 1'b0;
    drive(1'b1, 3'd4, 8'h0F, 8'hFF, 8'hF0); tick();
    drive(1'b1, 3'd1, 8'h10, 8'h20, 8'hF0); tick();
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    #1;
    chk("pre_rst_level", 32'(level), 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      logic [7:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = 8'($urandom);
      b  = 8'($urandom);
      drive(1'($urandom_range(0, 1)), op, a, b, model_result(op, a, b));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
